// File: rtl/fir_pkg.sv
// Sizing helpers and rounding/saturation used by the transposed FIR filter.
package fir_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((33'd1 << i) < 33'(n)) r = i + 32'd1;
      end
      return r;
   endfunction

   function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned n_taps);
      return data_w + coef_w + clog2(n_taps);
   endfunction

   // Round half up, arithmetic shift, then clamp to a signed out_w-bit range.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] a,
                                                    input int unsigned       shift,
                                                    input int unsigned       out_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (a + (64'sd1 <<< (shift - 32'd1))) >>> shift;
      hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 32'd1));
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-form tap: accumulates coef*x onto the incoming partial sum when enabled.
module fir_tap #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned ACC_W  = 27
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic signed [COEF_W-1:0] coef_i,
   input  logic signed [DATA_W-1:0] x_i,
   input  logic signed [ACC_W-1:0]  acc_i,
   output logic signed [ACC_W-1:0]  acc_o
);

   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

   // Product is formed at full accumulator width so it can never overflow.
   always_comb begin
      acc_d = acc_q;
      if (en_i) acc_d = acc_i + ACC_W'(coef_i) * ACC_W'(x_i);
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/fir_transposed_param.sv
// Parametrised transposed-form FIR with runtime-loadable coefficients.
// Define FIR_ROUND_SAT_EN for round-and-saturate output scaling; default truncates and wraps.
module fir_transposed_param
   import fir_pkg::*;
#(
   parameter int unsigned N_TAPS    = 7,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned COEF_W    = 16,
   parameter int unsigned OUT_W     = 10,
   parameter int unsigned OUT_SHIFT = 14
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic signed [DATA_W-1:0]        in_data,
   input  logic                            coef_we,
   input  logic [clog2(N_TAPS)-1:0]        coef_addr,
   input  logic signed [COEF_W-1:0]        coef_data,
   output logic                            out_valid,
   output logic signed [OUT_W-1:0]         out_data
);

   localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, N_TAPS);

   logic signed [COEF_W-1:0] coef_q [N_TAPS];
   logic signed [COEF_W-1:0] coef_d [N_TAPS];
   logic signed [DATA_W-1:0] x_q;
   logic signed [DATA_W-1:0] x_d;
   logic                     v_q;
   logic                     v2_q;
   logic                     out_valid_q;
   logic signed [OUT_W-1:0]  out_data_q;
   logic signed [OUT_W-1:0]  out_data_d;
   logic signed [ACC_W-1:0]  acc_w [N_TAPS];
   logic signed [ACC_W-1:0]  acc_last_c;
   logic signed [OUT_W-1:0]  scaled_c;

   // Coefficient file; out-of-range addresses are dropped.
   always_comb begin
      coef_d = coef_q;
      if (coef_we && (32'(coef_addr) < N_TAPS)) coef_d[coef_addr] = coef_data;
   end

   assign x_d = in_valid ? in_data : x_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_TAPS; i++) coef_q[i] <= '0;
         x_q  <= '0;
         v_q  <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         coef_q <= coef_d;
         x_q    <= x_d;
         v_q    <= in_valid;
         v2_q   <= v_q;
      end
   end

   // Tap k weights x with coef[N-1-k]; the chain end carries sum coef[j]*x[n-j].
   for (genvar k = 0; k < int'(N_TAPS); k++) begin : g_tap
      if (k == 0) begin : g_first
         fir_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap (
            .clk    (clk),
            .rst    (rst),
            .en_i   (v_q),
            .coef_i (coef_q[N_TAPS-1]),
            .x_i    (x_q),
            .acc_i  ('0),
            .acc_o  (acc_w[0])
         );
      end else begin : g_rest
         fir_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_tap (
            .clk    (clk),
            .rst    (rst),
            .en_i   (v_q),
            .coef_i (coef_q[int'(N_TAPS)-1-k]),
            .x_i    (x_q),
            .acc_i  (acc_w[k-1]),
            .acc_o  (acc_w[k])
         );
      end
   end

   assign acc_last_c = acc_w[N_TAPS-1];

`ifdef FIR_ROUND_SAT_EN
   assign scaled_c = OUT_W'(round_sat(64'(acc_last_c), OUT_SHIFT, OUT_W));
`else
   assign scaled_c = OUT_W'(acc_last_c >>> OUT_SHIFT);
`endif

   assign out_data_d = v2_q ? scaled_c : out_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= v2_q;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_transposed_param.sv
// Directed bench: impulse/bubble/reset/coef-write tests via scoreboard, plus default-config saturation/wrap.
module tb_fir_transposed_param;

   localparam int NT = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_a, iv_a, we_a, ov_a;
   logic signed [7:0] id_a;
   logic [2:0]        ca_a;
   logic signed [15:0] cd_a;
   logic signed [15:0] od_a;

   logic              rst_d, iv_d, we_d, ov_d;
   logic signed [7:0] id_d;
   logic [2:0]        ca_d;
   logic signed [15:0] cd_d;
   logic signed [9:0] od_d;

   fir_transposed_param #(.N_TAPS(7), .DATA_W(8), .COEF_W(16), .OUT_W(16), .OUT_SHIFT(1)) dut_a (
      .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_data(id_a), .coef_we(we_a),
      .coef_addr(ca_a), .coef_data(cd_a), .out_valid(ov_a), .out_data(od_a));

   fir_transposed_param dut_d (
      .clk(clk), .rst(rst_d), .in_valid(iv_d), .in_data(id_d), .coef_we(we_d),
      .coef_addr(ca_d), .coef_data(cd_d), .out_valid(ov_d), .out_data(od_d));

`ifdef FIR_ROUND_SAT_EN
   localparam int EXP_POS = 511;
   localparam int EXP_NEG = -512;
`else
   localparam int EXP_POS = -271;
   localparam int EXP_NEG = 256;
`endif

   typedef struct { logic signed [15:0] data; int due; } exp_t;
   exp_t   q[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc    = 0;
   longint m_coef [NT];
   longint hist   [NT];

   function automatic logic signed [15:0] scale_ref(input longint a);
      longint r;
`ifdef FIR_ROUND_SAT_EN
      r = (a + 1) >>> 1;
      if (r > 32767)       r = 32767;
      else if (r < -32768) r = -32768;
`else
      r = a >>> 1;
`endif
      return 16'(r);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (ov_a === 1'b1) begin
         if (q.size() == 0) chk("spurious_out_valid", ov_a, 0);
         else begin
            e = q.pop_front();
            chk("out_data", od_a, e.data);
            chk("out_latency", cyc, e.due);
         end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         chk("missing_out_valid", ov_a, 1);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      for (int j = 0; j < NT; j++) begin
         m_coef[j] = 0;
         hist[j]   = 0;
      end
      q.delete();
   endtask

   task automatic drive_a(input bit v, input int x, input bit we, input int addr, input int cdat);
      longint s;
      exp_t   e;
      iv_a = v; id_a = 8'(x); we_a = we; ca_a = 3'(addr); cd_a = 16'(cdat);
      if (we && addr < NT) m_coef[addr] = cdat;
      if (v) begin
         for (int j = NT - 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = x;
         s = 0;
         for (int j = 0; j < NT; j++) s += m_coef[j] * hist[j];
         e.data = scale_ref(s);
         e.due  = cyc + 3;
         q.push_back(e);
      end
      tick();
      iv_a = 1'b0; we_a = 1'b0;
   endtask

   task automatic load_ramp_a();
      for (int j = 0; j < NT; j++) drive_a(0, 0, 1, j, 2 * (j + 1));
   endtask

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_a = 1'b1; iv_a = 1'b0; we_a = 1'b0; id_a = '0; ca_a = '0; cd_a = '0;
      rst_d = 1'b1; iv_d = 1'b0; we_d = 1'b0; id_d = '0; ca_d = '0; cd_d = '0;
      model_reset();
      idle_a(3);
      chk("reset_ov_a", ov_a, 0);
      chk("reset_od_a", od_a, 0);
      chk("reset_ov_d", ov_d, 0);
      chk("reset_od_d", od_d, 0);
      rst_a = 1'b0; rst_d = 1'b0;

      // Impulse, back-to-back samples
      load_ramp_a();
      drive_a(1, 1, 0, 0, 0);
      for (int i = 0; i < 9; i++) drive_a(1, 0, 0, 0, 0);
      idle_a(4);

      // Impulse with two bubbles between samples
      drive_a(1, 1, 0, 0, 0);
      idle_a(2);
      for (int i = 0; i < 8; i++) begin
         drive_a(1, 0, 0, 0, 0);
         idle_a(2);
      end
      idle_a(4);

      // Reset mid-stream clears history and coefficients
      drive_a(1, 1, 0, 0, 0);
      drive_a(1, 0, 0, 0, 0);
      drive_a(1, 0, 0, 0, 0);
      rst_a = 1'b1;
      tick();
      model_reset();
      chk("midrst_ov", ov_a, 0);
      chk("midrst_od", od_a, 0);
      rst_a = 1'b0;
      drive_a(1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive_a(1, 0, 0, 0, 0);
      idle_a(4);

      // Coef write coincident with sample; out-of-range address ignored
      load_ramp_a();
      drive_a(1, 1, 1, 0, 10);
      for (int i = 0; i < 8; i++) drive_a(1, 0, 0, 0, 0);
      idle_a(4);
      drive_a(0, 0, 1, 7, 1234);
      drive_a(1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive_a(1, 0, 0, 0, 0);
      idle_a(4);

      // Default configuration, full-scale coefficients and samples
      for (int j = 0; j < NT; j++) begin
         we_d = 1'b1; ca_d = 3'(j); cd_d = 16'sd32767;
         tick();
      end
      we_d = 1'b0;
      iv_d = 1'b1; id_d = 8'sd127;
      idle_a(12);
      chk("dflt_pos_ov", ov_d, 1);
      chk("dflt_pos_od", od_d, EXP_POS);
      id_d = -8'sd128;
      idle_a(12);
      chk("dflt_neg_ov", ov_d, 1);
      chk("dflt_neg_od", od_d, EXP_NEG);
      iv_d = 1'b0;
      idle_a(4);
      chk("dflt_idle_ov", ov_d, 0);

      idle_a(4);
      chk("scoreboard_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
